matrix_scan_ctrl: RTL and testbench
===================================

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 Parameter COLS, default 64, meaning columns shifted per row-pair.
REQ-002 Parameter ROWS, default 16, meaning row-pair addresses per frame.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  scan enable; sampled in IDLE and at row end.
REQ-006 brightness  input  8  OE-active cycles per row; sampled at LATCH.
REQ-007 rd_req  output  1  framebuffer read request; held until rd_ack.
REQ-008 rd_addr  output  10  framebuffer address {row[3:0], col[5:0]}; stable while rd_req=1.
REQ-009 rd_ack  input  1  framebuffer accepts the request; rgb_in valid in the same cycle.
REQ-010 rgb_in  input  6  {R0,G0,B0,R1,G1,B1} for rd_addr.
REQ-011 rgb_out  output  6  registered panel pixel data.
REQ-012 sclk  output  1  panel shift clock; one-cycle high pulse per column.
REQ-013 lat  output  1  panel latch strobe.
REQ-014 oe  output  1  panel blank; 1 = LEDs off, 0 = row displayed.
REQ-015 row_addr  output  4  panel {D,C,B,A}.
REQ-016 frame_done  output  1  one-cycle pulse after row ROWS-1 completes display.

Function
REQ-017 FSM states: IDLE, FETCH, SHIFT, LATCH, DISPLAY.
REQ-018 IDLE: rd_req=0, oe=1; goes to FETCH with col=0 when en=1.
REQ-019 FETCH: rd_req=1, rd_addr={row,col}; on rd_ack, rgb_out<=rgb_in and next state is SHIFT; wait states are unbounded.
REQ-020 SHIFT: sclk=1 for exactly one cycle with rgb_out stable; col<COLS-1 -> col+1, FETCH; col=COLS-1 -> LATCH.
REQ-021 oe=1 throughout FETCH, SHIFT and LATCH.
REQ-022 LATCH: lat=1 for one cycle; row_addr<=row at this edge; brightness captured into on-time counter.
REQ-023 DISPLAY: oe=0 for exactly the captured brightness cycles; brightness=0 skips DISPLAY and oe stays 1.
REQ-024 Row end: row wraps ROWS-1 -> 0 (4-bit modulo), col<=0; frame_done=1 on the wrap cycle only.
REQ-025 Row end with en=1 -> FETCH; en=0 -> IDLE.
REQ-026 en deasserting mid-row does not abort; the current row completes shift, latch and display.
REQ-027 Minimum row period = 2*COLS + 1 + brightness cycles with zero-wait rd_ack.
REQ-028 rd_ack outside FETCH is ignored.
REQ-029 rgb_in is sampled only when rd_req and rd_ack are both 1.

Reset
REQ-030 While rst=1 at a clock edge:
  - state=IDLE, row=0, col=0.
  - rd_req=0, sclk=0, lat=0, frame_done=0, rgb_out=0, row_addr=0.
  - oe=1.
REQ-031 rst mid-row takes effect at the next edge with no completion of the pending column, latch or display.

Structure
REQ-032 Shared package matrix_pkg holds the state enum, COLS, ROWS, COL_W=6, ROW_W=4 and the RGB width 6.
REQ-033 On-time counter is one sub-module, matrix_oe_timer (load, count-down, done).

Verification
REQ-034 en=1, brightness=3, rd_ack tied 1, rgb_in=col[5:0] -> 64 sclk pulses carrying 0..63, one lat, oe=0 for 3 cycles, row period 132 cycles.
REQ-035 Random rd_ack stalls of 0-5 cycles -> rd_addr stable while rd_req=1, exactly 64 sclk per row, shifted data unchanged.
REQ-036 Run 16 rows -> row_addr goes 0..15 then 0; a single frame_done pulse at the 15->0 wrap.
REQ-037 brightness=0 -> oe never 0, row period 129 cycles; brightness changed mid-shift takes effect at the next LATCH.
REQ-038 en dropped at column 10 -> row completes with lat and display, then IDLE with rd_req=0 and oe=1.
REQ-039 rst asserted mid-FETCH -> next edge gives rd_req=0, oe=1, row_addr=0, state IDLE; restart begins at rd_addr=0.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared geometry, widths and scan FSM states for the LED matrix scan controller.
package matrix_pkg;
    localparam int COLS = 64;
    localparam int ROWS = 16;
    localparam int COL_W = 6;
    localparam int ROW_W = 4;
    localparam int RGB_W = 6;
    localparam int ADDR_W = ROW_W + COL_W;
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LATCH, DISPLAY} state_t;
endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// matrix_scan_ctrl_if: framebuffer read handshake between scan controller (master) and pixel memory (slave).
interface matrix_scan_ctrl_if;
    import matrix_pkg::*;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [RGB_W-1:0]  rgb_in;
    modport master (output rd_req, rd_addr, input rd_ack, rgb_in);
    modport slave (input rd_req, rd_addr, output rd_ack, rgb_in);
endinterface

// File: rtl/matrix_oe_timer.sv
// matrix_oe_timer: loadable down-counter timing the OE-active window of one row.
module matrix_oe_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] val_i,
    input  logic       dec_i,
    output logic       done_o
);
    logic [7:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    // done flags the final display cycle so the FSM leaves exactly after the loaded count
    assign done_o = cnt_q <= 8'd1;
endmodule

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: fetches a row-pair from the framebuffer, shifts it into a HUB75-style panel,
// latches it and lights it for a brightness-controlled number of cycles.
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int COLS = matrix_pkg::COLS,
    parameter int ROWS = matrix_pkg::ROWS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [7:0]         brightness,
    matrix_scan_ctrl_if.master fb,
    output logic [RGB_W-1:0]   rgb_out,
    output logic               sclk,
    output logic               lat,
    output logic               oe,
    output logic [ROW_W-1:0]   row_addr,
    output logic               frame_done
);
    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d, row_addr_q, row_addr_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             fd_q, fd_d, oe_done, row_end;

    matrix_oe_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == LATCH),
        .val_i  (brightness),
        .dec_i  (state_q == DISPLAY),
        .done_o (oe_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            row_addr_q <= '0;
            rgb_q      <= '0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_addr_q <= row_addr_d;
            rgb_q      <= rgb_d;
            fd_q       <= fd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_addr_d = row_addr_q;
        rgb_d      = rgb_q;
        fd_d       = 1'b0;
        row_end    = 1'b0;
        case (state_q)
            IDLE:    state_d = en ? FETCH : IDLE;
            FETCH: begin
                rgb_d   = fb.rd_ack ? fb.rgb_in : rgb_q;
                state_d = fb.rd_ack ? SHIFT : FETCH;
            end
            SHIFT: begin
                state_d = (col_q == COL_W'(COLS - 1)) ? LATCH : FETCH;
                col_d   = (col_q == COL_W'(COLS - 1)) ? col_q : col_q + 1'b1;
            end
            LATCH: begin
                row_addr_d = row_q;
                state_d    = DISPLAY;
                row_end    = brightness == 8'd0;
            end
            DISPLAY: row_end = oe_done;
            default: state_d = IDLE;
        endcase
        // row end overrides the per-state choice: advance the row and re-sample en
        if (row_end) begin
            row_d   = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
            col_d   = '0;
            fd_d    = row_q == ROW_W'(ROWS - 1);
            state_d = en ? FETCH : IDLE;
        end
    end

    assign fb.rd_req   = state_q == FETCH;
    assign fb.rd_addr  = {row_q, col_q};
    assign sclk        = state_q == SHIFT;
    assign lat         = state_q == LATCH;
    assign oe          = state_q != DISPLAY;
    assign rgb_out     = rgb_q;
    assign row_addr    = row_addr_q;
    assign frame_done  = fd_q;
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb_matrix_scan_ctrl: per-row scoreboard of fetches, shifted data, latch, display window and period.
module tb_matrix_scan_ctrl;
    localparam int COLS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] brightness = 8'd0;
    logic [5:0] rgb_out;
    logic       sclk, lat, oe, frame_done;
    logic [3:0] row_addr;
    int         n_chk = 0, n_fail = 0, fd_cnt = 0;
    logic [3:0] exp_row = 4'd0;

    matrix_scan_ctrl_if fb ();

    matrix_scan_ctrl #(.COLS(64), .ROWS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .brightness (brightness),
        .fb         (fb.master),
        .rgb_out    (rgb_out),
        .sclk       (sclk),
        .lat        (lat),
        .oe         (oe),
        .row_addr   (row_addr),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (frame_done) fd_cnt++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [7:0] b0;
        logic [7:0] b1;
        int         max_stall;
        int         drop_col;
        int         exp_oe;
        int         base;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [5:0] fbd(input logic [9:0] a);
        return a[5:0] ^ {2'b00, a[9:6]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start();
        en = 1'b1;
        @(negedge clk);
    endtask

    // Called at the negedge of a row's first cycle; returns at the negedge of the following row's first cycle.
    task automatic run_row(input logic [7:0] b0, input logic [7:0] b1, input int max_stall,
                           input int drop_col, input int exp_oe, input int base);
        int cyc = 0, nsclk = 0, nlat = 0, noe = 0, stall_tot = 0, wait_left = -1;
        int addr_err = 0, data_err = 0, seq_err = 0;
        logic [9:0] req_addr = '0;
        logic [5:0] expq[$];
        bit lat_seen = 0, done = 0;
        brightness = b0;
        while (!done && cyc < 2000) begin
            if (lat_seen && !lat && oe) done = 1;
            else begin
                cyc++;
                if (sclk) begin
                    if (expq.size() == 0 || rgb_out != expq[0]) data_err++;
                    if (expq.size() != 0) void'(expq.pop_front());
                    nsclk++;
                    if (nsclk == 30) brightness = b1;
                    if (nsclk == drop_col) en = 1'b0;
                end
                if (lat) begin
                    nlat++;
                    lat_seen = 1;
                end
                if (!oe) noe++;
                if (fb.rd_req) begin
                    if (wait_left < 0) begin
                        wait_left = $urandom_range(0, max_stall);
                        stall_tot += wait_left;
                        req_addr = fb.rd_addr;
                        if (fb.rd_addr != {exp_row, 6'(nsclk)}) seq_err++;
                    end else if (fb.rd_addr != req_addr) addr_err++;
                    if (wait_left == 0) begin
                        fb.rd_ack = 1'b1;
                        fb.rgb_in = fbd(req_addr);
                        expq.push_back(fbd(req_addr));
                        wait_left = -1;
                    end else begin
                        fb.rd_ack = 1'b0;
                        fb.rgb_in = 6'($urandom);
                        wait_left--;
                    end
                end else begin
                    fb.rd_ack = 1'($urandom);
                    fb.rgb_in = 6'($urandom);
                end
                @(negedge clk);
            end
        end
        check("row_finished", int'(done), 1);
        check("sclk_count", nsclk, COLS);
        check("shift_data_errors", data_err, 0);
        check("addr_sequence_errors", seq_err, 0);
        check("addr_unstable_errors", addr_err, 0);
        check("lat_count", nlat, 1);
        check("oe_low_cycles", noe, exp_oe);
        check("row_period", cyc, base + stall_tot);
        check("row_addr", int'(row_addr), int'(exp_row));
        exp_row = exp_row + 4'd1;
    endtask

    initial begin
        int bad;
        logic [7:0] b;
        vecs[0] = '{8'd3,   8'd3,   0, -1, 3,   132};
        vecs[1] = '{8'd0,   8'd0,   0, -1, 0,   129};
        vecs[2] = '{8'd3,   8'd7,   2, -1, 7,   136};
        vecs[3] = '{8'd1,   8'd1,   5, -1, 1,   130};
        vecs[4] = '{8'd255, 8'd255, 0, -1, 255, 384};
        vecs[5] = '{8'd5,   8'd5,   3, 10, 5,   134};
        fb.rd_ack = 1'b0;
        fb.rgb_in = '0;
        repeat (3) @(negedge clk);
        check("rst_rd_req", int'(fb.rd_req), 0);
        check("rst_sclk", int'(sclk), 0);
        check("rst_lat", int'(lat), 0);
        check("rst_oe", int'(oe), 1);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_rgb_out", int'(rgb_out), 0);
        check("rst_row_addr", int'(row_addr), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_req", int'(fb.rd_req), 0);
        start();
        foreach (vecs[i]) run_row(vecs[i].b0, vecs[i].b1, vecs[i].max_stall, vecs[i].drop_col,
                                  vecs[i].exp_oe, vecs[i].base);
        bad = 0;
        repeat (5) begin
            if (fb.rd_req || !oe) bad++;
            @(negedge clk);
        end
        check("idle_after_en_drop", bad, 0);
        start();
        for (int r = 6; r < 15; r++) begin
            b = 8'($urandom_range(0, 20));
            run_row(b, b, 5, -1, int'(b), 2 * COLS + 1 + int'(b));
        end
        check("no_frame_done_before_wrap", fd_cnt, 0);
        b = 8'($urandom_range(0, 20));
        run_row(b, b, 5, 20, int'(b), 2 * COLS + 1 + int'(b));
        bad = 0;
        repeat (4) begin
            if (fb.rd_req || !oe) bad++;
            @(negedge clk);
        end
        check("idle_after_frame", bad, 0);
        check("frame_done_pulses", fd_cnt, 1);
        start();
        run_row(8'd2, 8'd2, 0, -1, 2, 131);
        bad = 0;
        for (int n = 0, k = 0; k < 200; k++) begin
            if (sclk) n++;
            if (n == 5 && fb.rd_req) break;
            bad = k + 1;
            fb.rd_ack = fb.rd_req;
            fb.rgb_in = fbd(fb.rd_addr);
            @(negedge clk);
        end
        check("mid_fetch_col", int'(fb.rd_addr[5:0]), 5);
        fb.rd_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rd_req", int'(fb.rd_req), 0);
        check("midrst_oe", int'(oe), 1);
        check("midrst_row_addr", int'(row_addr), 0);
        check("midrst_sclk", int'(sclk), 0);
        check("midrst_rgb_out", int'(rgb_out), 0);
        rst = 1'b0;
        @(negedge clk);
        check("restart_rd_req", int'(fb.rd_req), 1);
        check("restart_rd_addr", int'(fb.rd_addr), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
